ssp_fifo_ctrl: RTL and testbench

SSP_FIFO_CTRL -- requirements
Module: ssp_fifo_ctrl

---
 rtl/ssp_fifo_ctrl_if.sv | 26 ++
 rtl/ssp_fifo_ctrl.sv | 77 +++++++
 tb/tb_ssp_fifo_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ssp_fifo_ctrl_if.sv
// rtl/ssp_fifo_ctrl_if.sv - processor, serializer and deserializer signal bundle for ssp_fifo_ctrl
interface ssp_fifo_ctrl_if;
  logic       PSEL;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic [7:0] TxData;
  logic       TxIsEmpty;
  logic       TxValidWord;
  logic       TxNextWord;
  logic [7:0] RxData;
  logic       RxNextWord;
  logic       SSPTXINTR;
  logic       SSPRXINTR;
  logic       SSPRXOVR;

  modport slave (
    input  PSEL, PWRITE, PWDATA, TxNextWord, RxData, RxNextWord,
    output PRDATA, TxData, TxIsEmpty, TxValidWord, SSPTXINTR, SSPRXINTR, SSPRXOVR
  );

  modport master (
    output PSEL, PWRITE, PWDATA, TxNextWord, RxData, RxNextWord,
    input  PRDATA, TxData, TxIsEmpty, TxValidWord, SSPTXINTR, SSPRXINTR, SSPRXOVR
  );
endinterface

// File: rtl/ssp_fifo_ctrl.sv
// rtl/ssp_fifo_ctrl.sv - 4-entry TX and RX FIFOs between processor bus and SSP serializer
module ssp_fifo_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic            PCLK,
  input  logic            CLEAR_B,
  ssp_fifo_ctrl_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       tx_mem_q [DEPTH];
  logic [7:0]       rx_mem_q [DEPTH];
  logic [PTR_W-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PTR_W-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic             rx_ovr_q, rx_ovr_d;

  logic tx_push, tx_pop, rx_push, rx_pop;

  // Full/empty gating alone yields the simultaneous push/pop rules:
  // a full FIFO only pops, an empty one only pushes.
  always_comb begin
    tx_push   = bus.PSEL & bus.PWRITE & (tx_cnt_q != FULL_CNT);
    tx_pop    = bus.TxNextWord & (tx_cnt_q != '0);
    rx_push   = bus.RxNextWord & (rx_cnt_q != FULL_CNT);
    rx_pop    = bus.PSEL & ~bus.PWRITE & (rx_cnt_q != '0);

    tx_wptr_d = tx_push ? tx_wptr_q + PTR_W'(1) : tx_wptr_q;
    tx_rptr_d = tx_pop  ? tx_rptr_q + PTR_W'(1) : tx_rptr_q;
    tx_cnt_d  = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);

    rx_wptr_d = rx_push ? rx_wptr_q + PTR_W'(1) : rx_wptr_q;
    rx_rptr_d = rx_pop  ? rx_rptr_q + PTR_W'(1) : rx_rptr_q;
    rx_cnt_d  = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);

    rx_ovr_d  = rx_ovr_q | (bus.RxNextWord & (rx_cnt_q == FULL_CNT));
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      rx_ovr_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_ovr_q  <= rx_ovr_d;
      if (tx_push) tx_mem_q[tx_wptr_q] <= bus.PWDATA;
      if (rx_push) rx_mem_q[rx_wptr_q] <= bus.RxData;
    end
  end

  // Head words are forced to zero when empty so stale entries never leak out.
  assign bus.TxData      = (tx_cnt_q == '0) ? 8'h00 : tx_mem_q[tx_rptr_q];
  assign bus.PRDATA      = (rx_cnt_q == '0) ? 8'h00 : rx_mem_q[rx_rptr_q];
  assign bus.TxIsEmpty   = (tx_cnt_q == '0);
  assign bus.TxValidWord = (tx_cnt_q != '0);
  assign bus.SSPTXINTR   = (tx_cnt_q == FULL_CNT);
  assign bus.SSPRXINTR   = (rx_cnt_q == FULL_CNT);
  assign bus.SSPRXOVR    = rx_ovr_q;

endmodule

// File: tb/tb_ssp_fifo_ctrl.sv
// tb/tb_ssp_fifo_ctrl.sv - directed and randomized checks of ssp_fifo_ctrl against a queue model
module tb_ssp_fifo_ctrl;

  logic pclk;
  logic clear_b;
  int   checks;
  int   failures;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       ovr_m;

  ssp_fifo_ctrl_if ssp ();

  ssp_fifo_ctrl #(.DEPTH(4)) dut (
    .PCLK    (pclk),
    .CLEAR_B (clear_b),
    .bus     (ssp.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".TxData"},      ssp.TxData,      (tx_q.size() != 0) ? tx_q[0] : 8'h00);
    chk({tag, ".TxIsEmpty"},   {7'd0, ssp.TxIsEmpty},   {7'd0, tx_q.size() == 0});
    chk({tag, ".TxValidWord"}, {7'd0, ssp.TxValidWord}, {7'd0, tx_q.size() != 0});
    chk({tag, ".SSPTXINTR"},   {7'd0, ssp.SSPTXINTR},   {7'd0, tx_q.size() == 4});
    chk({tag, ".PRDATA"},      ssp.PRDATA,      (rx_q.size() != 0) ? rx_q[0] : 8'h00);
    chk({tag, ".SSPRXINTR"},   {7'd0, ssp.SSPRXINTR},   {7'd0, rx_q.size() == 4});
    chk({tag, ".SSPRXOVR"},    {7'd0, ssp.SSPRXOVR},    {7'd0, ovr_m});
  endtask

  task automatic idle_inputs();
    ssp.PSEL       = 1'b0;
    ssp.PWRITE     = 1'b0;
    ssp.PWDATA     = 8'h00;
    ssp.TxNextWord = 1'b0;
    ssp.RxData     = 8'h00;
    ssp.RxNextWord = 1'b0;
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    ovr_m = 1'b0;
  endtask

  // One clock of stimulus; the model advances from the pre-edge occupancy.
  task automatic step(input string tag, input logic psel, input logic pwrite, input logic [7:0] pwdata,
                      input logic txnext, input logic [7:0] rxdata, input logic rxnext);
    bit tx_do_pop, tx_do_push, rx_do_pop, rx_do_push;
    ssp.PSEL       = psel;
    ssp.PWRITE     = pwrite;
    ssp.PWDATA     = pwdata;
    ssp.TxNextWord = txnext;
    ssp.RxData     = rxdata;
    ssp.RxNextWord = rxnext;
    @(posedge pclk);
    tx_do_pop  = txnext && tx_q.size() > 0;
    tx_do_push = psel && pwrite && tx_q.size() < 4;
    rx_do_pop  = psel && !pwrite && rx_q.size() > 0;
    rx_do_push = rxnext && rx_q.size() < 4;
    if (rxnext && rx_q.size() == 4) ovr_m = 1'b1;
    if (tx_do_pop)  void'(tx_q.pop_front());
    if (tx_do_push) tx_q.push_back(pwdata);
    if (rx_do_pop)  void'(rx_q.pop_front());
    if (rx_do_push) rx_q.push_back(rxdata);
    #1;
    idle_inputs();
    check_all(tag);
  endtask

  task automatic twr(input string tag, input logic [7:0] d);
    step(tag, 1'b1, 1'b1, d, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic tpop(input string tag);
    step(tag, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic rpush(input string tag, input logic [7:0] d);
    step(tag, 1'b0, 1'b0, 8'h00, 1'b0, d, 1'b1);
  endtask

  task automatic rread(input string tag);
    step(tag, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    idle_inputs();
    clear_b = 1'b1;
    #1 clear_b = 1'b0;
    #2 check_all("reset_async");
    repeat (2) @(posedge pclk);
    #1 check_all("reset_held");
    @(negedge pclk);
    clear_b = 1'b1;

    // Basic TX write/pop with zero-latency head visibility.
    twr("a5", 8'hA5);
    chk("a5.head", ssp.TxData, 8'hA5);
    twr("3c", 8'h3C);
    tpop("pop1");
    chk("pop1.head", ssp.TxData, 8'h3C);
    tpop("pop2");
    chk("pop2.empty", {7'd0, ssp.TxIsEmpty}, 8'h01);
    chk("pop2.data", ssp.TxData, 8'h00);

    // TX full: fifth write dropped.
    for (int i = 1; i <= 5; i++) begin
      twr($sformatf("txfill%0d", i), 8'(i));
      if (i == 4) chk("txfull.intr", {7'd0, ssp.SSPTXINTR}, 8'h01);
    end
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("txdrain%0d.head", i), ssp.TxData, 8'(i));
      tpop($sformatf("txdrain%0d", i));
    end

    // Full TX with simultaneous write and pop: pop only.
    for (int i = 0; i < 4; i++) twr("fill4", 8'h20 + 8'(i));
    step("full_wr_pop", 1'b1, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0);
    chk("full_wr_pop.intr", {7'd0, ssp.SSPTXINTR}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk("no_ff", {7'd0, ssp.TxData == 8'hFF}, 8'h00);
      tpop("drain3");
    end
    chk("drain3.empty", {7'd0, ssp.TxIsEmpty}, 8'h01);

    // RX overrun.
    for (int i = 0; i < 5; i++) rpush($sformatf("rx%0d", i), 8'h10 + 8'(i));
    chk("rx.ovr", {7'd0, ssp.SSPRXOVR}, 8'h01);
    chk("rx.intr", {7'd0, ssp.SSPRXINTR}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rxread%0d.head", i), ssp.PRDATA, 8'h10 + 8'(i));
      rread($sformatf("rxread%0d", i));
    end
    chk("rx.empty_data", ssp.PRDATA, 8'h00);
    chk("rx.ovr_sticky", {7'd0, ssp.SSPRXOVR}, 8'h01);

    // Pointer wrap with concurrent push/pop.
    twr("wrap_seed", 8'h40);
    for (int i = 1; i <= 6; i++) step($sformatf("wrap%0d", i), 1'b1, 1'b1, 8'h40 + 8'(i), 1'b1, 8'h00, 1'b0);
    chk("wrap.head", ssp.TxData, 8'h46);
    tpop("wrap_drain");

    // Reset mid-frame with buffered words.
    twr("mf_tx0", 8'h51);
    twr("mf_tx1", 8'h52);
    rpush("mf_rx0", 8'h61);
    rpush("mf_rx1", 8'h62);
    rpush("mf_rx2", 8'h63);
    #2 clear_b = 1'b0;
    #1 model_reset();
    check_all("midreset");
    @(negedge pclk);
    clear_b = 1'b1;
    twr("post_rst", 8'h77);
    chk("post_rst.head", ssp.TxData, 8'h77);
    tpop("post_rst_pop");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
